// File: rtl/decoration_sequencer.sv
// decoration_sequencer: plays a latched 4-slot opcode program, holding each slot
// HOLD_CYCLES clocks and driving the color, sound and effect actuators from it.
module decoration_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8,
    parameter bit          LOOP        = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [15:0] program_i,
    output logic [1:0]  slot_o,
    output logic [3:0]  opcode_o,
    output logic [2:0]  color_led_o,
    output logic        sound_req_o,
    output logic [1:0]  sound_id_o,
    output logic [2:0]  effect_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    typedef struct packed {
        logic       illegal;
        logic       clr;
        logic       set_color;
        logic [2:0] color;
        logic       sound;
        logic [1:0] sound_id;
        logic [2:0] effect;
    } dec_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    // Illegal opcodes decode to an all-zero action so the slot acts as a no-op.
    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '0;
        d.illegal = (op[1:0] == 2'b11) || (op[3:1] == 3'b001);
        if (!d.illegal) begin
            unique case (op[3:2])
                2'b00: d.clr = op[0];
                2'b01: begin
                    d.set_color = 1'b1;
                    d.color     = 3'b001 << op[1:0];
                end
                2'b10: begin
                    d.sound    = 1'b1;
                    d.sound_id = op[1:0];
                end
                default: d.effect = 3'b001 << op[1:0];
            endcase
        end
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [15:0]      prog_q, prog_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [2:0]       color_q, color_d;
    logic             sound_req_q, sound_req_d;
    logic [1:0]       sound_id_q, sound_id_d;
    logic [2:0]       effect_q, effect_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             enter;
    logic [3:0]       enter_op;
    logic [1:0]       slot_nx;
    dec_t             dec;
    dec_t             held_dec;

    assign held_dec = decode(opcode_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        slot_d      = slot_q;
        timer_d     = timer_q;
        prog_d      = prog_q;
        opcode_d    = opcode_q;
        color_d     = color_q;
        sound_req_d = 1'b0;
        sound_id_d  = sound_id_q;
        effect_d    = effect_q;
        done_d      = 1'b0;
        err_d       = err_q;
        enter       = 1'b0;
        enter_op    = 4'h0;
        slot_nx     = slot_q + 2'd1;

        if (state_q != S_IDLE && stop_i) begin
            state_d  = S_IDLE;
            slot_d   = 2'd0;
            opcode_d = 4'h0;
            color_d  = 3'b000;
            effect_d = 3'b000;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && on_i) begin
                        state_d  = S_RUN;
                        prog_d   = program_i;
                        slot_d   = 2'd0;
                        timer_d  = '0;
                        enter    = 1'b1;
                        enter_op = program_i[3:0];
                    end
                end
                S_RUN: begin
                    if (timer_q == LAST) begin
                        timer_d  = '0;
                        effect_d = 3'b000;
                        if (slot_q == 2'd3) begin
                            done_d = 1'b1;
                            slot_d = 2'd0;
                            if (LOOP) begin
                                enter    = 1'b1;
                                enter_op = prog_q[3:0];
                            end else begin
                                state_d  = S_IDLE;
                                opcode_d = 4'h0;
                            end
                        end else begin
                            slot_d   = slot_nx;
                            enter    = 1'b1;
                            enter_op = prog_q[{slot_nx, 2'b00} +: 4];
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (on_i) begin
                        state_d  = S_RUN;
                        effect_d = held_dec.effect;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        dec = decode(enter_op);
        if (enter) begin
            opcode_d = enter_op;
            effect_d = dec.effect;
            err_d    = err_q | dec.illegal;
            if (dec.clr)       color_d = 3'b000;
            if (dec.set_color) color_d = dec.color;
            if (dec.sound) begin
                sound_req_d = 1'b1;
                sound_id_d  = dec.sound_id;
            end
        end

        // The cycle in which on drops still counts toward the hold time.
        if (state_q == S_RUN && state_d == S_RUN && !on_i) begin
            state_d     = S_PAUSE;
            effect_d    = 3'b000;
            sound_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            timer_q     <= '0;
            prog_q      <= 16'h0000;
            opcode_q    <= 4'h0;
            color_q     <= 3'b000;
            sound_req_q <= 1'b0;
            sound_id_q  <= 2'b00;
            effect_q    <= 3'b000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            timer_q     <= timer_d;
            prog_q      <= prog_d;
            opcode_q    <= opcode_d;
            color_q     <= color_d;
            sound_req_q <= sound_req_d;
            sound_id_q  <= sound_id_d;
            effect_q    <= effect_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign slot_o      = slot_q;
    assign opcode_o    = opcode_q;
    assign color_led_o = color_q;
    assign sound_req_o = sound_req_q;
    assign sound_id_o  = sound_id_q;
    assign effect_o    = effect_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
